// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu peripheral responder: register offsets,
// control/status bit positions and the UART transmitter state encoding.
package dcpu_pkg;

  // Word offsets within the 16-byte window (i_addr[3:1])
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_RELOAD   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_IRQ      = 3'd4;
  localparam logic [2:0] REG_TXDATA   = 3'd5;
  localparam logic [2:0] REG_TXSTAT   = 3'd6;
  localparam logic [2:0] REG_BAUD     = 3'd7;

  // CTRL bit indices
  localparam int CTRL_TEN = 0;
  localparam int CTRL_ARL = 1;
  localparam int CTRL_TIE = 2;
  localparam int CTRL_XIE = 3;

  // IRQ_STATUS bit indices
  localparam int IRQ_TEXP   = 0;
  localparam int IRQ_TXDONE = 1;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/dcpu_uart_tx.sv
// 8N1 UART transmitter. Bit period is i_div+1 clocks; divisor and data are
// captured when a start request is accepted in IDLE, ignored otherwise.
module dcpu_uart_tx
  import dcpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_data,
  input  logic [15:0] i_div,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div, div_n;
  logic [7:0]  shreg, shreg_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        tx, tx_n;
  logic        bit_end;

  // State and datapath registers; reset aborts any frame and forces the line high
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= UART_IDLE;
      cnt     <= 16'd0;
      div     <= 16'd0;
      shreg   <= 8'd0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div     <= div_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  assign bit_end = (cnt == div);

  // Next-state logic; the line level is computed one clock ahead so o_tx is a flop
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_n     = div;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    tx_n      = tx;
    case (state)
      UART_IDLE: begin
        if (i_start) begin
          state_n   = UART_START;
          cnt_n     = 16'd0;
          div_n     = i_div;
          shreg_n   = i_data;
          bit_idx_n = 3'd0;
          tx_n      = 1'b0;
        end else begin
          tx_n      = 1'b1;
        end
      end
      UART_START: begin
        if (bit_end) begin
          state_n = UART_DATA;
          cnt_n   = 16'd0;
          tx_n    = shreg[0];
        end else begin
          cnt_n   = cnt + 16'd1;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (bit_idx == 3'd7) begin
            state_n = UART_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          state_n = UART_IDLE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n   = cnt + 16'd1;
        end
      end
      default: begin
        state_n = UART_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign o_tx   = tx;
  assign o_busy = (state != UART_IDLE);
  // Pulses on the last STOP clock so the status flag sets on the edge that returns to IDLE
  assign o_done = (state == UART_STOP) && bit_end;

endmodule

// File: rtl/dcpu_periph.sv
// Memory-mapped peripheral responder for the dcpu bus: address decode,
// register file, prescaled down-counting timer and interrupt unit, with an
// 8N1 UART transmitter instance. Reads are combinational and side-effect free.
module dcpu_periph
  import dcpu_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  input  logic        i_rw,
  output logic [15:0] o_dat,
  output logic        o_sel,
  output logic        o_int,
  output logic        o_tx
);

  logic [3:0]  ctrl;
  logic [15:0] reload, count, prescale, baud, pcnt;
  logic [1:0]  irq;
  logic [2:0]  off;
  logic        we, tick, expire, tx_busy, tx_done, tx_start;
  logic [1:0]  irq_clr, irq_set;
  logic [15:0] rdata;
  logic        unused_addr_bit;

  assign o_sel           = (i_addr[15:4] == BASE[15:4]);
  assign off             = i_addr[3:1];
  assign we              = o_sel & ~i_rw;
  assign unused_addr_bit = i_addr[0];

  assign tick     = ctrl[CTRL_TEN] && (pcnt == prescale);
  assign expire   = tick && (count == 16'd0);
  assign tx_start = we && (off == REG_TXDATA);
  assign irq_set  = {tx_done, expire};

  // Write-1-to-clear mask for the status register
  always_comb begin
    irq_clr = 2'b00;
    if (we && (off == REG_IRQ)) begin
      irq_clr = i_dat[1:0];
    end else begin
      irq_clr = 2'b00;
    end
  end

  // Plain configuration registers written directly by the CPU
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reload   <= 16'd0;
      prescale <= 16'd0;
      baud     <= 16'd1;
    end else if (we) begin
      case (off)
        REG_RELOAD:   reload   <= i_dat;
        REG_PRESCALE: prescale <= i_dat;
        REG_BAUD:     baud     <= i_dat;
        default:      ;
      endcase
    end
  end

  // CTRL: a CPU write takes priority over the one-shot expiry clearing TEN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl <= 4'd0;
    end else if (we && (off == REG_CTRL)) begin
      ctrl <= i_dat[3:0];
    end else if (expire && !ctrl[CTRL_ARL]) begin
      ctrl[CTRL_TEN] <= 1'b0;
    end
  end

  // Prescaler: runs 0..PRESCALE while enabled, parked at 0 otherwise
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pcnt <= 16'd0;
    end else if (!ctrl[CTRL_TEN] || (pcnt == prescale)) begin
      pcnt <= 16'd0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // COUNT: CPU write wins over a same-cycle tick
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= 16'd0;
    end else if (we && (off == REG_COUNT)) begin
      count <= i_dat;
    end else if (tick) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (ctrl[CTRL_ARL]) begin
        count <= reload;
      end else begin
        count <= 16'd0;
      end
    end
  end

  // Interrupt flags (set beats clear) and the registered request line
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      irq   <= 2'b00;
      o_int <= 1'b0;
    end else begin
      irq   <= (irq & ~irq_clr) | irq_set;
      o_int <= (irq[IRQ_TEXP] & ctrl[CTRL_TIE]) | (irq[IRQ_TXDONE] & ctrl[CTRL_XIE]);
    end
  end

  // Read mux; TX_DATA reads back as zero
  always_comb begin
    rdata = 16'd0;
    case (off)
      REG_CTRL:     rdata = {12'd0, ctrl};
      REG_RELOAD:   rdata = reload;
      REG_COUNT:    rdata = count;
      REG_PRESCALE: rdata = prescale;
      REG_IRQ:      rdata = {14'd0, irq};
      REG_TXDATA:   rdata = 16'd0;
      REG_TXSTAT:   rdata = {15'd0, tx_busy};
      REG_BAUD:     rdata = baud;
      default:      rdata = 16'd0;
    endcase
  end

  assign o_dat = o_sel ? rdata : 16'd0;

  dcpu_uart_tx u_uart_tx (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (tx_start),
    .i_data    (i_dat[7:0]),
    .i_div     (baud),
    .o_tx      (o_tx),
    .o_busy    (tx_busy),
    .o_done    (tx_done)
  );

endmodule

// File: tb/tb_dcpu_periph.sv
// Directed self-checking bench for dcpu_periph: decode, timer one-shot and
// auto-reload, UART frame, simultaneous set/clear and reset mid-frame.
module tb_dcpu_periph;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic        rw;
  logic [15:0] rdat;
  logic        sel;
  logic        irq_line;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcpu_periph #(.BASE(16'hFF00)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_addr    (addr),
    .i_dat     (wdat),
    .i_rw      (rw),
    .o_dat     (rdat),
    .o_sel     (sel),
    .o_int     (irq_line),
    .o_tx      (tx)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write during the current cycle; returns in the following cycle
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    wdat = d;
    rw   = 1'b0;
    @(negedge clk);
    rw   = 1'b1;
    addr = 16'h0000;
  endtask

  // Combinational read within the current cycle
  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a;
    rw   = 1'b1;
    #1;
    d = rdat;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    logic [9:0]  frame;
    frame = {1'b1, 8'hA5, 1'b0};

    rst_n = 1'b0;
    addr  = 16'h0000;
    wdat  = 16'h0000;
    rw    = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    rd(16'hFF00, v); check("rst_ctrl", v, 16'h0000);
    rd(16'hFF0E, v); check("rst_baud", v, 16'h0001);
    rd(16'hFF04, v); check("rst_count", v, 16'h0000);
    check("rst_tx", {15'd0, tx}, 16'h0001);
    check("rst_int", {15'd0, irq_line}, 16'h0000);

    // Decode
    wr(16'hFF06, 16'h1234);
    rd(16'hFF06, v); check("hit_sel", {15'd0, sel}, 16'h0001); check("hit_dat", v, 16'h1234);
    rd(16'hFE06, v); check("miss_sel", {15'd0, sel}, 16'h0000); check("miss_dat", v, 16'h0000);
    wr(16'hFE06, 16'h5555);
    rd(16'hFF06, v); check("miss_wr", v, 16'h1234);

    // Timer one-shot: CTRL written at edge W, TEXP sets at edge W+8
    wr(16'hFF06, 16'h0001);
    wr(16'hFF04, 16'h0003);
    wr(16'hFF00, 16'h0005);               // now in cycle W+1
    step(7);                              // cycle W+8
    rd(16'hFF08, v); check("os_texp_pre", v, 16'h0000);
    rd(16'hFF04, v); check("os_count0", v, 16'h0000);
    step(1);                              // cycle W+9
    rd(16'hFF08, v); check("os_texp", v, 16'h0001);
    check("os_int_pre", {15'd0, irq_line}, 16'h0000);
    step(1);                              // cycle W+10
    check("os_int", {15'd0, irq_line}, 16'h0001);
    rd(16'hFF00, v); check("os_ten_off", v, 16'h0004);
    step(3);
    rd(16'hFF04, v); check("os_count_hold", v, 16'h0000);
    wr(16'hFF08, 16'h0001);               // clear at edge X, now X+1
    rd(16'hFF08, v); check("os_w1c", v, 16'h0000);
    check("os_int_lag", {15'd0, irq_line}, 16'h0001);
    step(1);
    check("os_int_fall", {15'd0, irq_line}, 16'h0000);

    // Timer auto-reload: expiries at edges W+1, W+6, W+11
    wr(16'hFF06, 16'h0000);
    wr(16'hFF02, 16'h0004);
    wr(16'hFF00, 16'h0003);               // cycle W+1
    rd(16'hFF08, v); check("ar_pre", v, 16'h0000);
    step(1);                              // W+2
    rd(16'hFF08, v); check("ar_first", v, 16'h0001);
    rd(16'hFF04, v); check("ar_reload", v, 16'h0004);
    wr(16'hFF08, 16'h0001);               // clear at edge W+2, now W+3
    rd(16'hFF08, v); check("ar_w1c", v, 16'h0000);
    step(3);                              // W+6
    rd(16'hFF08, v); check("ar_gap", v, 16'h0000);
    step(1);                              // W+7
    rd(16'hFF08, v); check("ar_second", v, 16'h0001);
    wr(16'hFF08, 16'h0001);               // clear at edge W+7, now W+8
    step(3);                              // W+11
    wr(16'hFF08, 16'h0001);               // clear coincides with expiry at edge W+11
    rd(16'hFF08, v); check("set_beats_clr", v, 16'h0001);
    check("ar_no_int", {15'd0, irq_line}, 16'h0000);
    wr(16'hFF00, 16'h0000);
    wr(16'hFF08, 16'h0003);
    rd(16'hFF08, v); check("irq_cleared", v, 16'h0000);

    // UART frame 0xA5 at BAUD_DIV=3; a second write while busy is dropped
    wr(16'hFF0E, 16'h0003);
    wr(16'hFF0A, 16'h00A5);               // cycle k+1: START begins
    for (int i = 0; i < 40; i++) begin
      rd(16'hFF0C, v);
      check($sformatf("tx_busy_%0d", i), v, 16'h0001);
      check($sformatf("tx_bit_%0d", i), {15'd0, tx}, {15'd0, frame[i / 4]});
      if (i == 2) begin
        addr = 16'hFF0A;
        wdat = 16'h003C;
        rw   = 1'b0;
      end
      @(negedge clk);
    end
    rd(16'hFF0C, v); check("tx_idle", v, 16'h0000);
    check("tx_high", {15'd0, tx}, 16'h0001);
    rd(16'hFF08, v); check("tx_done", v, 16'h0002);
    rd(16'hFF0A, v); check("txdata_rd0", v, 16'h0000);
    step(5);
    rd(16'hFF0C, v); check("tx_dropped", v, 16'h0000);

    // Reset mid-frame
    wr(16'hFF00, 16'h0008);
    step(1);
    check("xie_int", {15'd0, irq_line}, 16'h0001);
    wr(16'hFF02, 16'h0077);
    wr(16'hFF0A, 16'h005A);               // cycle k+1
    step(5);                              // k+6: first data bit (0)
    check("mid_bit0", {15'd0, tx}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {15'd0, tx}, 16'h0001);
    check("rst_mid_int", {15'd0, irq_line}, 16'h0000);
    rd(16'hFF0C, v); check("rst_mid_busy", v, 16'h0000);
    rd(16'hFF00, v); check("rst_mid_ctrl", v, 16'h0000);
    rd(16'hFF02, v); check("rst_mid_reload", v, 16'h0000);
    rd(16'hFF06, v); check("rst_mid_presc", v, 16'h0000);
    rd(16'hFF08, v); check("rst_mid_irq", v, 16'h0000);
    rd(16'hFF0E, v); check("rst_mid_baud", v, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("post_rst_tx", {15'd0, tx}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
